// File: rtl/result_dumper_if.sv
// rtl/result_dumper_if.sv - memory read port, pixel stream and status bundle for result_dumper
interface result_dumper_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int CSUM_W = 22
);
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic [DATA_W-1:0] data_rd;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dumping;
  logic              done;
  logic [CSUM_W-1:0] checksum;

  // Dumper side: drives the read port, the stream and the status outputs.
  modport master (
    input  busy, data_rd, dout_ready,
    output addr, rd, dout, dout_valid, dumping, done, checksum
  );

  // Environment side: filter status, result memory and stream consumer.
  modport slave (
    output busy, data_rd, dout_ready,
    input  addr, rd, dout, dout_valid, dumping, done, checksum
  );
endinterface

// File: rtl/result_dumper.sv
// rtl/result_dumper.sv - reads the result memory in raster order and streams it out with a checksum
module result_dumper #(
  parameter int NPIX   = 16384,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int CSUM_W = 22
) (
  input  logic           clk,
  input  logic           reset,
  result_dumper_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  state_e            state_q, state_d;
  logic              busy_q;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q;
  logic              done_q, done_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        credit;

  // Next-state logic: start detect, credit-limited read issue, 2-entry output FIFO, checksum.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    csum_d   = csum_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    pop    = (cnt_q != 2'd0) && bus.dout_ready;
    push   = inflight_q;
    // Slots already claimed once this cycle's pop frees one; a read is allowed while fewer than 2.
    credit = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue  = (state_q == READ) && (credit < 3'd2);

    if (pop) begin
      csum_d = csum_q + {{(CSUM_W-DATA_W){1'b0}}, head_q};
      beat_d = beat_q + ADDR_W'(1);
    end

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = bus.data_rd;
        else               tail_d = bus.data_rd;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = bus.data_rd;
        end else begin
          head_d = tail_q;
          tail_d = bus.data_rd;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        // Only a falling edge of busy seen while idle starts a dump.
        if (busy_q && !bus.busy) begin
          state_d  = READ;
          rd_ptr_d = '0;
          beat_d   = '0;
          csum_d   = '0;
        end
      end
      READ: begin
        // The pointer parks on the last address so addr never leaves the image.
        if (issue) begin
          if (rd_ptr_q == LAST) state_d  = DRAIN;
          else                  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (pop && (beat_q == LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset back to an idle, empty engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      csum_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= bus.busy;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      csum_q     <= csum_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  assign bus.rd         = issue;
  assign bus.addr       = rd_ptr_q;
  assign bus.dout       = head_q;
  assign bus.dout_valid = (cnt_q != 2'd0);
  assign bus.dumping    = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.checksum   = csum_q;

endmodule

// File: tb/tb_result_dumper.sv
// tb/tb_result_dumper.sv - randomized self-checking bench for result_dumper
module tb_result_dumper;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CSUM_W = 22;
  localparam int NA = 16384;
  localparam int NB = 4;
  localparam int NC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int density = 50;

  result_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W)) ifa ();
  result_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W)) ifb ();
  result_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W)) ifc ();

  result_dumper #(.NPIX(NA), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W))
    dut_a (.clk(clk), .reset(rst), .bus(ifa.master));
  result_dumper #(.NPIX(NB), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W))
    dut_b (.clk(clk), .reset(rst), .bus(ifb.master));
  result_dumper #(.NPIX(NC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W))
    dut_c (.clk(clk), .reset(rst), .bus(ifc.master));

  logic [2:0] busy_s  = 3'b000;
  logic [2:0] ready_s = 3'b000;
  logic [2:0] clr     = 3'b000;

  logic [7:0] mem_a [NA];
  logic [7:0] mem_b [NB];
  logic [7:0] mem_c [NC];
  logic [7:0] rdata_a = 8'd0;
  logic [7:0] rdata_b = 8'd0;
  logic [7:0] rdata_c = 8'd0;

  assign ifa.busy = busy_s[0];
  assign ifb.busy = busy_s[1];
  assign ifc.busy = busy_s[2];
  assign ifa.dout_ready = ready_s[0];
  assign ifb.dout_ready = ready_s[1];
  assign ifc.dout_ready = ready_s[2];
  assign ifa.data_rd = rdata_a;
  assign ifb.data_rd = rdata_b;
  assign ifc.data_rd = rdata_c;

  // Result memories: data is returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (ifa.rd) rdata_a <= mem_a[ifa.addr];
    if (ifb.rd) rdata_b <= mem_b[ifb.addr[1:0]];
    if (ifc.rd) rdata_c <= mem_c[ifc.addr[3:0]];
  end

  wire [2:0]        w_rd      = {ifc.rd, ifb.rd, ifa.rd};
  wire [2:0]        w_valid   = {ifc.dout_valid, ifb.dout_valid, ifa.dout_valid};
  wire [2:0]        w_done    = {ifc.done, ifb.done, ifa.done};
  wire [2:0]        w_dumping = {ifc.dumping, ifb.dumping, ifa.dumping};
  wire [2:0][13:0]  w_addr    = {ifc.addr, ifb.addr, ifa.addr};
  wire [2:0][7:0]   w_dout    = {ifc.dout, ifb.dout, ifa.dout};
  wire [2:0][21:0]  w_csum    = {ifc.checksum, ifb.checksum, ifa.checksum};

  int npix [3] = '{NA, NB, NC};
  int rd_n [3];
  int beat_n [3];
  int done_n [3];
  int first_rd [3];
  int first_addr [3];
  int first_valid [3];
  int last_beat [3];
  int done_at [3];
  int viol_stable [3];
  int viol_out [3];
  int viol_addr [3];
  int viol_dump [3];
  logic [2:0] pv_stall = 3'b000;
  logic [7:0] pv_dout [3];
  logic [7:0] beats [3][$];

  // Observer on the falling edge: collects beats, read/done timing and protocol violations.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (clr[k]) begin
        rd_n[k] <= 0; beat_n[k] <= 0; done_n[k] <= 0;
        first_rd[k] <= -1; first_addr[k] <= -1; first_valid[k] <= -1;
        last_beat[k] <= -1; done_at[k] <= -1;
        viol_stable[k] <= 0; viol_out[k] <= 0; viol_addr[k] <= 0; viol_dump[k] <= 0;
        pv_stall[k] <= 1'b0;
        beats[k].delete();
      end else begin
        if (w_rd[k]) begin
          rd_n[k] <= rd_n[k] + 1;
          if (rd_n[k] == 0) begin
            first_rd[k]   <= cyc;
            first_addr[k] <= int'(w_addr[k]);
          end
          if (int'(w_addr[k]) >= npix[k]) viol_addr[k] <= viol_addr[k] + 1;
        end
        if (w_valid[k] && first_valid[k] < 0) first_valid[k] <= cyc;
        if (pv_stall[k] && (!w_valid[k] || w_dout[k] !== pv_dout[k]))
          viol_stable[k] <= viol_stable[k] + 1;
        if (w_valid[k] && ready_s[k]) begin
          beats[k].push_back(w_dout[k]);
          beat_n[k]    <= beat_n[k] + 1;
          last_beat[k] <= cyc;
        end
        if ((rd_n[k] + int'(w_rd[k])) - (beat_n[k] + int'(w_valid[k] && ready_s[k])) > 2)
          viol_out[k] <= viol_out[k] + 1;
        if (w_done[k]) begin
          done_n[k] <= done_n[k] + 1;
          if (done_n[k] == 0) done_at[k] <= cyc;
          if (w_dumping[k]) viol_dump[k] <= viol_dump[k] + 1;
        end
        pv_stall[k] <= w_valid[k] && !ready_s[k];
        pv_dout[k]  <= w_dout[k];
      end
    end
  end

  // Reference model: the stream is the memory image in raster order, checksum is its plain sum.
  function automatic logic [7:0] exp_pix(input int k, input int i);
    case (k)
      0:       return mem_a[i];
      1:       return mem_b[i];
      default: return mem_c[i];
    endcase
  endfunction

  function automatic int ref_sum(input int k);
    int s = 0;
    for (int i = 0; i < npix[k]; i++) s += int'(exp_pix(k, i));
    return s;
  endfunction

  function automatic int seq_errors(input int k);
    int bad = 0;
    if (beats[k].size() != npix[k]) bad++;
    for (int i = 0; i < npix[k]; i++)
      if (i >= beats[k].size() || beats[k][i] !== exp_pix(k, i)) bad++;
    return bad;
  endfunction

  task automatic start_dump(input int k, output int e);
    clr[k] = 1'b1;
    @(posedge clk); #1;
    clr[k] = 1'b0;
    busy_s[k] = 1'b1;
    @(posedge clk); #1;
    busy_s[k] = 1'b0;
    e = cyc;
  endtask

  // Modes: 0 ready high, 1 ready 1,0,0,1, 2 random ready, 3 stall 10 cycles, 4 busy re-pulse.
  task automatic run_dump(input int k, input int mode, input int budget,
                          output int e, output int rd_at_release);
    int tail = 0;
    rd_at_release = -1;
    ready_s[k] = (mode == 3) ? 1'b0 : 1'b1;
    start_dump(k, e);
    for (int n = 0; n < budget && tail < 4; n++) begin
      @(posedge clk); #1;
      case (mode)
        1: ready_s[k] = (n % 4 == 0) || (n % 4 == 3);
        2: ready_s[k] = ($urandom_range(0, 99) < density);
        3: begin
          if (n == 10) rd_at_release = rd_n[k];
          ready_s[k] = (n >= 10);
        end
        4: begin
          if (n == 1) busy_s[k] = 1'b1;
          if (n == 2) busy_s[k] = 1'b0;
        end
        default: ready_s[k] = 1'b1;
      endcase
      if (done_n[k] > 0) tail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (w_rd[k] !== 1'b0) begin fails++; $display("FAIL reset_rd[%0d]: got %b want 0", k, w_rd[k]); end
      tests++; if (w_addr[k] !== 14'd0) begin fails++; $display("FAIL reset_addr[%0d]: got %0d want 0", k, w_addr[k]); end
      tests++; if (w_dout[k] !== 8'd0) begin fails++; $display("FAIL reset_dout[%0d]: got %0d want 0", k, w_dout[k]); end
      tests++; if (w_valid[k] !== 1'b0) begin fails++; $display("FAIL reset_valid[%0d]: got %b want 0", k, w_valid[k]); end
      tests++; if (w_dumping[k] !== 1'b0) begin fails++; $display("FAIL reset_dumping[%0d]: got %b want 0", k, w_dumping[k]); end
      tests++; if (w_done[k] !== 1'b0) begin fails++; $display("FAIL reset_done[%0d]: got %b want 0", k, w_done[k]); end
      tests++; if (w_csum[k] !== 22'd0) begin fails++; $display("FAIL reset_checksum[%0d]: got %0d want 0", k, w_csum[k]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_stream();
    int e, x, err;
    for (int i = 0; i < NA; i++) mem_a[i] = 8'(i);
    run_dump(0, 0, NA + 20, e, x);
    err = seq_errors(0);
    tests++; if (beat_n[0] != NA) begin fails++; $display("FAIL full_beats: got %0d want %0d", beat_n[0], NA); end
    tests++; if (err != 0) begin fails++; $display("FAIL full_sequence: %0d wrong beats", err); end
    tests++; if (int'(w_csum[0]) != ref_sum(0)) begin fails++; $display("FAIL full_checksum: got %0d want %0d", w_csum[0], ref_sum(0)); end
    tests++; if (first_rd[0] != e + 1) begin fails++; $display("FAIL full_first_rd: got cycle %0d want %0d", first_rd[0], e + 1); end
    tests++; if (first_addr[0] != 0) begin fails++; $display("FAIL full_first_addr: got %0d want 0", first_addr[0]); end
    tests++; if (first_valid[0] != e + 3) begin fails++; $display("FAIL full_first_valid: got cycle %0d want %0d", first_valid[0], e + 3); end
    tests++; if (last_beat[0] != e + NA + 2) begin fails++; $display("FAIL full_last_beat: got cycle %0d want %0d", last_beat[0], e + NA + 2); end
    tests++; if (done_at[0] != e + NA + 3) begin fails++; $display("FAIL full_done_cycle: got %0d want %0d", done_at[0], e + NA + 3); end
    tests++; if (done_n[0] != 1) begin fails++; $display("FAIL full_done_count: got %0d want 1", done_n[0]); end
    tests++; if (viol_dump[0] != 0) begin fails++; $display("FAIL full_dumping_at_done: got %0d want 0", viol_dump[0]); end
    tests++; if (viol_addr[0] != 0) begin fails++; $display("FAIL full_addr_range: got %0d want 0", viol_addr[0]); end
  endtask

  task automatic test_toggle_ready();
    int e, x, err;
    run_dump(0, 1, 2 * NA + 200, e, x);
    err = seq_errors(0);
    tests++; if (beat_n[0] != NA) begin fails++; $display("FAIL toggle_beats: got %0d want %0d", beat_n[0], NA); end
    tests++; if (err != 0) begin fails++; $display("FAIL toggle_sequence: %0d wrong beats", err); end
    tests++; if (int'(w_csum[0]) != ref_sum(0)) begin fails++; $display("FAIL toggle_checksum: got %0d want %0d", w_csum[0], ref_sum(0)); end
    tests++; if (viol_stable[0] != 0) begin fails++; $display("FAIL toggle_stall_stable: got %0d want 0", viol_stable[0]); end
    tests++; if (viol_out[0] != 0) begin fails++; $display("FAIL toggle_outstanding: got %0d want 0", viol_out[0]); end
    tests++; if (viol_addr[0] != 0) begin fails++; $display("FAIL toggle_addr_range: got %0d want 0", viol_addr[0]); end
    tests++; if (rd_n[0] != NA) begin fails++; $display("FAIL toggle_reads: got %0d want %0d", rd_n[0], NA); end
    tests++; if (done_n[0] != 1) begin fails++; $display("FAIL toggle_done_count: got %0d want 1", done_n[0]); end
  endtask

  task automatic test_stall_start();
    int e, rel, err;
    for (int i = 0; i < NB; i++) mem_b[i] = 8'd255;
    run_dump(1, 3, 60, e, rel);
    err = seq_errors(1);
    tests++; if (rel != 2) begin fails++; $display("FAIL stall_reads_before_release: got %0d want 2", rel); end
    tests++; if (beat_n[1] != NB) begin fails++; $display("FAIL stall_beats: got %0d want %0d", beat_n[1], NB); end
    tests++; if (err != 0) begin fails++; $display("FAIL stall_sequence: %0d wrong beats", err); end
    tests++; if (int'(w_csum[1]) != ref_sum(1)) begin fails++; $display("FAIL stall_checksum: got %0d want %0d", w_csum[1], ref_sum(1)); end
    tests++; if (done_n[1] != 1) begin fails++; $display("FAIL stall_done_count: got %0d want 1", done_n[1]); end
    tests++; if (viol_stable[1] != 0) begin fails++; $display("FAIL stall_stable: got %0d want 0", viol_stable[1]); end
  endtask

  task automatic test_busy_retrigger();
    int e, x, err;
    for (int i = 0; i < NB; i++) mem_b[i] = 8'($urandom);
    run_dump(1, 4, 40, e, x);
    err = seq_errors(1);
    tests++; if (beat_n[1] != NB) begin fails++; $display("FAIL retrig_beats: got %0d want %0d", beat_n[1], NB); end
    tests++; if (rd_n[1] != NB) begin fails++; $display("FAIL retrig_reads: got %0d want %0d", rd_n[1], NB); end
    tests++; if (err != 0) begin fails++; $display("FAIL retrig_sequence: %0d wrong beats", err); end
    tests++; if (int'(w_csum[1]) != ref_sum(1)) begin fails++; $display("FAIL retrig_checksum: got %0d want %0d", w_csum[1], ref_sum(1)); end
    tests++; if (done_n[1] != 1) begin fails++; $display("FAIL retrig_done_count: got %0d want 1", done_n[1]); end
  endtask

  task automatic test_random_backpressure();
    int e, x, err;
    for (int r = 0; r < 4; r++) begin
      density = 25 + 20 * r;
      for (int i = 0; i < NC; i++) mem_c[i] = 8'($urandom);
      run_dump(2, 2, 600, e, x);
      err = seq_errors(2);
      tests++; if (err != 0) begin fails++; $display("FAIL rand_sequence[%0d]: %0d wrong beats", r, err); end
      tests++; if (int'(w_csum[2]) != ref_sum(2)) begin fails++; $display("FAIL rand_checksum[%0d]: got %0d want %0d", r, w_csum[2], ref_sum(2)); end
      tests++; if (done_n[2] != 1) begin fails++; $display("FAIL rand_done_count[%0d]: got %0d want 1", r, done_n[2]); end
      tests++; if (viol_stable[2] + viol_out[2] + viol_addr[2] != 0) begin
        fails++; $display("FAIL rand_protocol[%0d]: stable %0d outstanding %0d addr %0d want 0", r, viol_stable[2], viol_out[2], viol_addr[2]);
      end
      tests++; if (rd_n[2] != NC) begin fails++; $display("FAIL rand_reads[%0d]: got %0d want %0d", r, rd_n[2], NC); end
    end
  endtask

  task automatic test_reset_mid_read();
    int e, x, err;
    for (int i = 0; i < NC; i++) mem_c[i] = 8'($urandom_range(1, 255));
    ready_s[2] = 1'b1;
    start_dump(2, e);
    for (int n = 0; n < 30 && beat_n[2] < 3; n++) begin
      @(posedge clk); #1;
    end
    tests++; if (beat_n[2] != 3) begin fails++; $display("FAIL midrst_beats_before: got %0d want 3", beat_n[2]); end
    tests++; if (!(w_dumping[2] === 1'b1 && rd_n[2] < NC)) begin
      fails++; $display("FAIL midrst_in_read: dumping %b reads %0d want 1 and <%0d", w_dumping[2], rd_n[2], NC);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (w_rd[2] !== 1'b0) begin fails++; $display("FAIL midrst_rd: got %b want 0", w_rd[2]); end
    tests++; if (w_addr[2] !== 14'd0) begin fails++; $display("FAIL midrst_addr: got %0d want 0", w_addr[2]); end
    tests++; if (w_valid[2] !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", w_valid[2]); end
    tests++; if (w_dout[2] !== 8'd0) begin fails++; $display("FAIL midrst_dout: got %0d want 0", w_dout[2]); end
    tests++; if (w_dumping[2] !== 1'b0) begin fails++; $display("FAIL midrst_dumping: got %b want 0", w_dumping[2]); end
    tests++; if (w_csum[2] !== 22'd0) begin fails++; $display("FAIL midrst_checksum: got %0d want 0", w_csum[2]); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests++; if (done_n[2] != 0) begin fails++; $display("FAIL midrst_no_done: got %0d want 0", done_n[2]); end
    tests++; if (w_dumping[2] !== 1'b0) begin fails++; $display("FAIL midrst_no_restart: dumping %b want 0", w_dumping[2]); end
    run_dump(2, 0, NC + 20, e, x);
    err = seq_errors(2);
    tests++; if (first_addr[2] != 0) begin fails++; $display("FAIL midrst_restart_addr: got %0d want 0", first_addr[2]); end
    tests++; if (first_rd[2] != e + 1) begin fails++; $display("FAIL midrst_restart_rd: got cycle %0d want %0d", first_rd[2], e + 1); end
    tests++; if (err != 0) begin fails++; $display("FAIL midrst_restart_sequence: %0d wrong beats", err); end
    tests++; if (int'(w_csum[2]) != ref_sum(2)) begin fails++; $display("FAIL midrst_restart_checksum: got %0d want %0d", w_csum[2], ref_sum(2)); end
    tests++; if (done_n[2] != 1) begin fails++; $display("FAIL midrst_restart_done: got %0d want 1", done_n[2]); end
  endtask

  initial begin
    for (int i = 0; i < NA; i++) mem_a[i] = 8'd0;
    for (int i = 0; i < NB; i++) mem_b[i] = 8'd0;
    for (int i = 0; i < NC; i++) mem_c[i] = 8'd0;
    test_reset();
    test_full_stream();
    test_toggle_ready();
    test_stall_start();
    test_busy_retrigger();
    test_random_backpressure();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
